// File: rtl/lecture_timer.sv
// lecture_timer
//   Game-time base for the lecture game. Divides Clk into game seconds and
//   minutes, applies minute penalties on request and flags expiry. All
//   outputs are registered.
//
//   Optional feature macro: LECTURE_TIMER_BCD_EN
//     defined     -> minutes_bcd / seconds_bcd track minutes / seconds in BCD
//     not defined -> minutes_bcd / seconds_bcd are tied to 0
//
// Parameters
//   TICKS_PER_SEC  Clk cycles per game second (>= 2)
//   SEC_PER_MIN    game seconds per game minute (2..64)
//   MAX_MINUTES    expired is high while minutes >= MAX_MINUTES
//   PENALTY_MIN    minutes added per Penalty pulse (1..255)
//
// Ports
//   Clk          in   system clock
//   Reset        in   synchronous, active-high; clears all state
//   Run          in   time advances only while high
//   Clear        in   one-cycle pulse; restart at 00:00
//   Penalty      in   one-cycle pulse; add PENALTY_MIN minutes
//   minutes      out  [7:0]  elapsed minutes, saturating at 255
//   seconds      out  [5:0]  seconds within current minute
//   sec_tick     out  pulse with each seconds update
//   min_tick     out  pulse with each rollover minute increment
//   expired      out  minutes >= MAX_MINUTES
//   minutes_bcd  out  [11:0] three BCD digits of minutes
//   seconds_bcd  out  [7:0]  two BCD digits of seconds
module lecture_timer #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int SEC_PER_MIN   = 60,
    parameter int MAX_MINUTES   = 120,
    parameter int PENALTY_MIN   = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Clear,
    input  logic        Penalty,
    output logic [7:0]  minutes,
    output logic [5:0]  seconds,
    output logic        sec_tick,
    output logic        min_tick,
    output logic        expired,
    output logic [11:0] minutes_bcd,
    output logic [7:0]  seconds_bcd
);

    localparam int                PRE_W    = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [5:0]        SEC_LAST = 6'(SEC_PER_MIN - 1);
    localparam logic [8:0]        PEN_9    = 9'(PENALTY_MIN);
    localparam logic [31:0]       MAX_32   = 32'(MAX_MINUTES);

    // Add in 9 bits, then clamp to 255.
    function automatic logic [7:0] sat_add(input logic [7:0] base,
                                           input logic [8:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + inc;
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_next;
    logic [5:0]       seconds_next;
    logic [7:0]       minutes_next;
    logic             sec_tick_next;
    logic             min_tick_next;
    logic             expired_next;
    logic             sec_elapse;
    logic             rollover;

    always_comb begin
        pre_next      = pre;
        seconds_next  = seconds;
        minutes_next  = minutes;
        sec_tick_next = 1'b0;
        min_tick_next = 1'b0;
        sec_elapse    = Run && (pre == PRE_LAST);
        rollover      = sec_elapse && (seconds == SEC_LAST);

        if (Clear) begin
            pre_next     = '0;
            seconds_next = '0;
            minutes_next = '0;
        end else begin
            if (Run) begin
                pre_next = (pre == PRE_LAST) ? '0 : pre + PRE_ONE;
            end
            if (sec_elapse) begin
                sec_tick_next = 1'b1;
                seconds_next  = rollover ? 6'd0 : seconds + 6'd1;
            end
            // A penalty absorbs a coincident rollover minute and never ticks.
            if (Penalty) begin
                minutes_next = sat_add(minutes, PEN_9 + {8'd0, rollover});
            end else if (rollover && (minutes != 8'hFF)) begin
                minutes_next  = minutes + 8'd1;
                min_tick_next = 1'b1;
            end
        end

        // Derived from the next value so it moves together with minutes.
        expired_next = ({24'd0, minutes_next} >= MAX_32);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pre      <= '0;
            seconds  <= '0;
            minutes  <= '0;
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            expired  <= (MAX_MINUTES <= 0);
        end else begin
            pre      <= pre_next;
            seconds  <= seconds_next;
            minutes  <= minutes_next;
            sec_tick <= sec_tick_next;
            min_tick <= min_tick_next;
            expired  <= expired_next;
        end
    end

`ifdef LECTURE_TIMER_BCD_EN
    // Double-dabble: 8-bit binary to three BCD digits.
    function automatic logic [11:0] bcd_of_min(input logic [7:0] bin);
        logic [11:0] bcd;
        bcd = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], bin[i]};
        end
        return bcd;
    endfunction

    // Double-dabble: 6-bit binary to two BCD digits.
    function automatic logic [7:0] bcd_of_sec(input logic [5:0] bin);
        logic [7:0] bcd;
        bcd = '0;
        for (int i = 5; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[6:0], bin[i]};
        end
        return bcd;
    endfunction

    // Shadows load the converted next values, so they stay in lockstep.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            minutes_bcd <= '0;
            seconds_bcd <= '0;
        end else begin
            minutes_bcd <= bcd_of_min(minutes_next);
            seconds_bcd <= bcd_of_sec(seconds_next);
        end
    end
`else
    assign minutes_bcd = '0;
    assign seconds_bcd = '0;
`endif

endmodule

// File: tb/tb_lecture_timer.sv
// tb_lecture_timer
//   Self-checking bench for lecture_timer with small parameters
//   (4 ticks/second, 3 seconds/minute, expiry at 120, penalty 5).
//   A time-keeping model in plain integer arithmetic predicts every output.
module tb_lecture_timer;

    localparam int TPS  = 4;
    localparam int SPM  = 3;
    localparam int MAXM = 120;
    localparam int PEN  = 5;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Run = 1'b0;
    logic        Clear = 1'b0;
    logic        Penalty = 1'b0;
    logic [7:0]  minutes;
    logic [5:0]  seconds;
    logic        sec_tick;
    logic        min_tick;
    logic        expired;
    logic [11:0] minutes_bcd;
    logic [7:0]  seconds_bcd;

    int vectors = 0;
    int miscompares = 0;

    // Model state: time expressed as plain integers.
    int m_pre = 0;
    int m_sec = 0;
    int m_min = 0;
    bit m_stick = 0;
    bit m_mtick = 0;

    always #5 Clk = ~Clk;

    lecture_timer #(
        .TICKS_PER_SEC(TPS),
        .SEC_PER_MIN  (SPM),
        .MAX_MINUTES  (MAXM),
        .PENALTY_MIN  (PEN)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Clear      (Clear),
        .Penalty    (Penalty),
        .minutes    (minutes),
        .seconds    (seconds),
        .sec_tick   (sec_tick),
        .min_tick   (min_tick),
        .expired    (expired),
        .minutes_bcd(minutes_bcd),
        .seconds_bcd(seconds_bcd)
    );

    function automatic logic [11:0] dec_min(input int m);
`ifdef LECTURE_TIMER_BCD_EN
        return 12'(((m / 100) << 8) | (((m / 10) % 10) << 4) | (m % 10));
`else
        return 12'(m * 0);
`endif
    endfunction

    function automatic logic [7:0] dec_sec(input int s);
`ifdef LECTURE_TIMER_BCD_EN
        return 8'(((s / 10) << 4) | (s % 10));
`else
        return 8'(s * 0);
`endif
    endfunction

    // Full expected output word in port order.
    function automatic logic [36:0] expected_word();
        return {8'(m_min), 6'(m_sec), m_stick, m_mtick, (m_min >= MAXM),
                dec_min(m_min), dec_sec(m_sec)};
    endfunction

    // Apply one cycle of inputs, advance the model, sample 1 time unit later.
    task automatic step(input bit run, input bit clr, input bit pen);
        int total;
        bit roll;
        Run = run;
        Clear = clr;
        Penalty = pen;
        @(posedge Clk);
        roll = 0;
        m_stick = 0;
        m_mtick = 0;
        if (Reset) begin
            m_pre = 0;
            m_sec = 0;
            m_min = 0;
        end else if (clr) begin
            m_pre = 0;
            m_sec = 0;
            m_min = 0;
        end else begin
            if (run) begin
                m_pre = m_pre + 1;
                if (m_pre == TPS) begin
                    m_pre = 0;
                    m_stick = 1;
                    m_sec = m_sec + 1;
                    if (m_sec == SPM) begin
                        m_sec = 0;
                        roll = 1;
                    end
                end
            end
            if (pen) begin
                total = m_min + PEN + int'(roll);
                m_min = (total > 255) ? 255 : total;
            end else if (roll && m_min < 255) begin
                m_min = m_min + 1;
                m_mtick = 1;
            end
        end
        #1;
        Run = 1'b0;
        Clear = 1'b0;
        Penalty = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step(1, 1, 1);
        step(1, 0, 1);
        Reset = 1'b0;
        vectors++;
        if ({minutes, seconds, sec_tick, min_tick, expired} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_state got m=%0d s=%0d st=%b mt=%b ex=%b want all 0",
                     minutes, seconds, sec_tick, min_tick, expired);
        end
        vectors++;
        if ({minutes_bcd, seconds_bcd} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_bcd got %h/%h want 0/0", minutes_bcd, seconds_bcd);
        end
    endtask

    task automatic test_first_minute();
        step(0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0);
            vectors++;
            if (sec_tick !== ((i % 4) == 0)) begin
                miscompares++;
                $display("FAIL first_sec_tick cycle %0d got %b want %b", i, sec_tick, (i % 4) == 0);
            end
        end
        vectors++;
        if ({minutes, seconds, min_tick, sec_tick} !== {8'd1, 6'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL first_minute got m=%0d s=%0d mt=%b st=%b want m=1 s=0 mt=1 st=1",
                     minutes, seconds, min_tick, sec_tick);
        end
    endtask

    task automatic test_expire();
        step(0, 1, 0);
        for (int i = 0; i < 23; i++) step(0, 0, 1);        // 115 minutes
        for (int i = 0; i < 4 * 12 + 8; i++) step(1, 0, 0); // 119:02, pre 0
        vectors++;
        if ({minutes, seconds, expired} !== {8'd119, 6'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL at_119 got m=%0d s=%0d ex=%b want 119 2 0", minutes, seconds, expired);
        end
        vectors++;
        if ({minutes_bcd, seconds_bcd} !== {dec_min(119), dec_sec(2)}) begin
            miscompares++;
            $display("FAIL bcd_119 got %h/%h want %h/%h", minutes_bcd, seconds_bcd,
                     dec_min(119), dec_sec(2));
        end
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        vectors++;
        if ({minutes, seconds, expired, min_tick} !== {8'd120, 6'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL expire_edge got m=%0d s=%0d ex=%b mt=%b want 120 0 1 1",
                     minutes, seconds, expired, min_tick);
        end
        step(1, 1, 0);
        vectors++;
        if ({minutes, seconds, expired, sec_tick} !== 16'd0) begin
            miscompares++;
            $display("FAIL clear_after_expire got m=%0d s=%0d ex=%b st=%b want 0 0 0 0",
                     minutes, seconds, expired, sec_tick);
        end
    endtask

    task automatic test_penalty_rollover();
        step(0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);            // 10 minutes
        for (int i = 0; i < 11; i++) step(1, 0, 0);
        step(1, 0, 1);            // rollover and penalty together
        vectors++;
        if ({minutes, seconds, min_tick, sec_tick} !== {8'd16, 6'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL penalty_rollover got m=%0d s=%0d mt=%b st=%b want 16 0 0 1",
                     minutes, seconds, min_tick, sec_tick);
        end
    endtask

    task automatic test_saturate();
        bit bad;
        step(0, 1, 0);
        for (int i = 0; i < 50; i++) step(0, 0, 1);    // 250
        for (int i = 0; i < 24; i++) step(1, 0, 0);    // 252
        step(0, 0, 1);
        vectors++;
        if (minutes !== 8'd255) begin
            miscompares++;
            $display("FAIL penalty_saturate got %0d want 255", minutes);
        end
        bad = 0;
        for (int i = 0; i < 36; i++) begin
            step(1, 0, 0);
            if (minutes !== 8'd255 || min_tick !== 1'b0 || seconds !== 6'(m_sec)) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL hold_at_255 got m=%0d mt=%b s=%0d want 255 0 %0d",
                     minutes, min_tick, seconds, m_sec);
        end
        vectors++;
        if ({minutes_bcd, expired} !== {dec_min(255), 1'b1}) begin
            miscompares++;
            $display("FAIL bcd_255 got %h ex=%b want %h 1", minutes_bcd, expired, dec_min(255));
        end
    endtask

    task automatic test_hold();
        bit bad;
        step(0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);                  // pre = 2
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            if (sec_tick !== 1'b0 || seconds !== 6'd0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL hold_no_advance got s=%0d st=%b want 0 0", seconds, sec_tick);
        end
        step(1, 0, 0);
        vectors++;
        if (sec_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL resume_early got st=%b want 0", sec_tick);
        end
        step(1, 0, 0);
        vectors++;
        if ({sec_tick, seconds} !== {1'b1, 6'd1}) begin
            miscompares++;
            $display("FAIL resume_tick got st=%b s=%0d want 1 1", sec_tick, seconds);
        end
        step(1, 1, 1);
        vectors++;
        if ({minutes, seconds, sec_tick} !== 15'd0) begin
            miscompares++;
            $display("FAIL clear_beats_penalty got m=%0d s=%0d st=%b want 0 0 0",
                     minutes, seconds, sec_tick);
        end
    endtask

    task automatic test_random();
        logic [36:0] got;
        logic [36:0] want;
        int          cnt;
        int          errs;
        bit          run;
        cnt = 0;
        errs = 0;
        run = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            Reset = ($urandom_range(0, 499) == 0);
            step(run, $urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0);
            Reset = 1'b0;
            got  = {minutes, seconds, sec_tick, min_tick, expired, minutes_bcd, seconds_bcd};
            want = expected_word();
            cnt++;
            if (got !== want) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random cycle %0d got %h want %h", i, got, want);
            end
        end
        vectors += cnt;
        miscompares += errs;
    endtask

    initial begin
        test_reset();
        test_first_minute();
        test_expire();
        test_penalty_rollover();
        test_saturate();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
